// File: rtl/e203_clk_pkg.sv
// Shared definitions for the E203 clock unit: sequencer state encoding and
// default bring-up timing.
package e203_clk_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      REL_SYS   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } clk_state_e;

   localparam int DEF_RST_CYC      = 16;
   localparam int DEF_LOCK_TIMEOUT = 4096;
   localparam int DEF_STABLE_CYC   = 256;
   localparam int DEF_RTC_DLY      = 8;
   localparam int DEF_MAX_RETRY    = 3;
   localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/e203_sync2.sv
// Generic two-flop synchronizer for single-bit level signals crossing into clk.
module e203_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/e203_pll_rst_seq.sv
// PLL bring-up and reset sequencer: pulses the PLL reset, supervises lock with
// timeout/retry, then releases sys and rtc resets in order.
module e203_pll_rst_seq
   import e203_clk_pkg::*;
#(
   parameter int RST_CYC      = DEF_RST_CYC,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYC   = DEF_STABLE_CYC,
   parameter int RTC_DLY      = DEF_RTC_DLY,
   parameter int MAX_RETRY    = DEF_MAX_RETRY,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       rtc_rst,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt
);

   localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
   localparam logic [CNT_W-1:0] STAB_LD = CNT_W'(STABLE_CYC - 2);
   localparam logic [CNT_W-1:0] RTC_LD  = CNT_W'(RTC_DLY - 1);
   localparam logic [CNT_W-1:0] TMR_ONE = CNT_W'(1);
   localparam logic [1:0]       MAX_R   = 2'(MAX_RETRY);

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      sat_inc = (v == 2'd3) ? v : v + 2'd1;
   endfunction

   logic             lock_s;
   clk_state_e       state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [1:0]       retry_q, retry_d;
   logic             fail_q, fail_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             rtc_rst_q, rtc_rst_d;
   logic             ready_q, ready_d;

   e203_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (clkin),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      retry_d = retry_q;
      fail_d  = fail_q;
      if (restart) begin
         state_d = PLL_RST;
         tmr_d   = RST_LD;
         retry_d = 2'd0;
         fail_d  = 1'b0;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (tmr_q == '0) begin
                  state_d = WAIT_LOCK;
                  tmr_d   = LOCK_LD;
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
                  tmr_d   = STAB_LD;
               end else if (tmr_q == '0) begin
                  retry_d = sat_inc(retry_q);
                  if (retry_q == MAX_R) begin
                     state_d = FAIL;
                     tmr_d   = '0;
                  end else begin
                     state_d = PLL_RST;
                     tmr_d   = RST_LD;
                  end
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
                  tmr_d   = LOCK_LD;
               end else if (tmr_q == '0) begin
                  state_d = REL_SYS;
                  tmr_d   = RTC_LD;
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
            REL_SYS: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
                  tmr_d   = LOCK_LD;
                  retry_d = 2'd0;
               end else if (tmr_q == '0) begin
                  state_d = RUN;
                  tmr_d   = '0;
                  retry_d = 2'd0;
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
                  tmr_d   = LOCK_LD;
                  retry_d = 2'd0;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = PLL_RST;
               tmr_d   = RST_LD;
            end
         endcase
         if (state_d == FAIL) fail_d = 1'b1;
      end
   end

   // Outputs decode the next state so they line up with state_q after the edge.
   always_comb begin
      pll_rst_d = (state_d == PLL_RST) || (state_d == FAIL);
      sys_rst_d = !((state_d == REL_SYS) || (state_d == RUN));
      rtc_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q   <= PLL_RST;
         tmr_q     <= RST_LD;
         retry_q   <= 2'd0;
         fail_q    <= 1'b0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         rtc_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         retry_q   <= retry_d;
         fail_q    <= fail_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         rtc_rst_q <= rtc_rst_d;
         ready_q   <= ready_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign rtc_rst   = rtc_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_e203_pll_rst_seq.sv
// Bench for e203_pll_rst_seq: directed bring-up timing scenarios plus a long
// randomized lock/restart/reset run checked every cycle against a phase model.
module tb_e203_pll_rst_seq;

   localparam int RST_CYC      = 4;
   localparam int LOCK_TIMEOUT = 32;
   localparam int STABLE_CYC   = 8;
   localparam int RTC_DLY      = 4;
   localparam int MAX_RETRY    = 3;

   logic       clkin    = 1'b0;
   logic       reset    = 1'b1;
   logic       pll_lock = 1'b0;
   logic       restart  = 1'b0;
   logic       pll_rst, sys_rst, rtc_rst, ready, fail;
   logic [1:0] retry_cnt;

   e203_pll_rst_seq #(
      .RST_CYC(RST_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYC(STABLE_CYC),
      .RTC_DLY(RTC_DLY), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
   ) dut (
      .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .restart(restart),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .rtc_rst(rtc_rst), .ready(ready),
      .fail(fail), .retry_cnt(retry_cnt)
   );

   always #5 clkin = ~clkin;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Phase model: durations counted upward, lock seen two edges late.
   typedef enum int {PH_PULSE, PH_SEEK, PH_SETTLE, PH_GAP, PH_UP, PH_DEAD} ph_t;
   ph_t ph = PH_PULSE;
   int  el = 0, hi = 0, m_retry = 0;
   bit  m_fail = 0, s1 = 0, s2 = 0;

   task automatic model_edge();
      bit ls;
      ls = s2;
      if (reset) begin
         ph = PH_PULSE; el = 0; hi = 0; m_retry = 0; m_fail = 0; s1 = 0; s2 = 0;
      end else begin
         if (restart) begin
            ph = PH_PULSE; el = 0; m_retry = 0; m_fail = 0;
         end else begin
            case (ph)
               PH_PULSE: begin
                  el++;
                  if (el == RST_CYC) begin ph = PH_SEEK; el = 0; end
               end
               PH_SEEK: begin
                  if (ls) begin
                     ph = PH_SETTLE; hi = 1;
                  end else begin
                     el++;
                     if (el == LOCK_TIMEOUT) begin
                        ph = (m_retry == MAX_RETRY) ? PH_DEAD : PH_PULSE;
                        m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                        el = 0;
                     end
                  end
               end
               PH_SETTLE: begin
                  if (!ls) begin
                     ph = PH_SEEK; el = 0;
                  end else begin
                     hi++;
                     if (hi == STABLE_CYC) begin ph = PH_GAP; el = 0; end
                  end
               end
               PH_GAP: begin
                  if (!ls) begin
                     ph = PH_SEEK; el = 0; m_retry = 0;
                  end else begin
                     el++;
                     if (el == RTC_DLY) begin ph = PH_UP; m_retry = 0; end
                  end
               end
               PH_UP: begin
                  if (!ls) begin ph = PH_SEEK; el = 0; m_retry = 0; end
               end
               default: ;
            endcase
            if (ph == PH_DEAD) m_fail = 1;
         end
         s2 = s1;
         s1 = pll_lock;
      end
   endtask

   task automatic compare_all();
      chk("pll_rst",   int'(pll_rst),   int'(ph == PH_PULSE || ph == PH_DEAD));
      chk("sys_rst",   int'(sys_rst),   int'(!(ph == PH_GAP || ph == PH_UP)));
      chk("rtc_rst",   int'(rtc_rst),   int'(ph != PH_UP));
      chk("ready",     int'(ready),     int'(ph == PH_UP));
      chk("fail",      int'(fail),      int'(m_fail));
      chk("retry_cnt", int'(retry_cnt), m_retry);
   endtask

   int cyc = 0;
   int sys_fall, rtc_fall, sys_rise, rtc_rise, pll_fall, pll_rises;
   logic p_pll, p_sys, p_rtc;

   task automatic clear_marks();
      sys_fall = -1; rtc_fall = -1; sys_rise = -1; rtc_rise = -1;
      pll_fall = -1; pll_rises = 0;
      p_pll = pll_rst; p_sys = sys_rst; p_rtc = rtc_rst;
   endtask

   task automatic step();
      @(posedge clkin);
      model_edge();
      @(negedge clkin);
      cyc++;
      compare_all();
      if (p_sys && !sys_rst && sys_fall < 0) sys_fall = cyc;
      if (p_rtc && !rtc_rst && rtc_fall < 0) rtc_fall = cyc;
      if (!p_sys && sys_rst && sys_rise < 0) sys_rise = cyc;
      if (!p_rtc && rtc_rst && rtc_rise < 0) rtc_rise = cyc;
      if (p_pll && !pll_rst && pll_fall < 0) pll_fall = cyc;
      if (!p_pll && pll_rst) pll_rises++;
      p_pll = pll_rst; p_sys = sys_rst; p_rtc = rtc_rst;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, int'(pll_rst), 1);
      chk({tag, "_sys_rst"}, int'(sys_rst), 1);
      chk({tag, "_rtc_rst"}, int'(rtc_rst), 1);
      chk({tag, "_ready"},   int'(ready),   0);
      chk({tag, "_fail"},    int'(fail),    0);
      chk({tag, "_retry"},   int'(retry_cnt), 0);
   endtask

   // Leaves reset deasserted with cyc=0 being the first cycle out of reset.
   task automatic do_reset(input int n);
      reset = 1'b1;
      restart = 1'b0;
      repeat (n) step();
      reset = 1'b0;
      cyc = 0;
      clear_marks();
   endtask

   initial begin
      int r, hold;

      // Nominal bring-up
      do_reset(3);
      chk_reset_vals("rst");
      while (cyc < 40) begin pll_lock = (cyc >= 10); step(); end
      chk("nom_pll_fall", pll_fall, 4);
      chk("nom_sys_fall", sys_fall, 10 + 2 + 8);
      chk("nom_rtc_fall", rtc_fall, 10 + 2 + 8 + 4);
      chk("nom_ready",    int'(ready), 1);
      chk("nom_retry",    int'(retry_cnt), 0);

      // Glitchy lock: high 5, low 1, then high
      pll_lock = 1'b0;
      do_reset(2);
      while (cyc < 40) begin pll_lock = (cyc >= 10 && cyc != 15); step(); end
      chk("glitch_sys_fall", sys_fall, 16 + 2 + 8);
      chk("glitch_rtc_fall", rtc_fall, 16 + 2 + 8 + 4);

      // Lock loss in RUN, then re-lock
      clear_marks();
      pll_lock = 1'b0;
      while (cyc < 46) step();
      chk("loss_sys_rise", sys_rise, 43);
      chk("loss_rtc_rise", rtc_rise, 43);
      chk("loss_ready",    int'(ready), 0);
      clear_marks();
      pll_lock = 1'b1;
      while (cyc < 70) step();
      chk("relock_sys_fall", sys_fall, 46 + 2 + 8);
      chk("relock_rtc_fall", rtc_fall, 46 + 2 + 8 + 4);

      // Timeout, retries and fail
      pll_lock = 1'b0;
      do_reset(2);
      while (cyc < 140) step();
      chk("to_pll_repulses", pll_rises, 3);
      chk("to_retry",        int'(retry_cnt), 3);
      chk("to_fail_early",   int'(fail), 0);
      while (cyc < 170) step();
      chk("to_fail",    int'(fail), 1);
      chk("to_pll_hold", int'(pll_rst), 1);
      chk("to_pll_rises", pll_rises, 4);
      restart = 1'b1;
      r = cyc;
      step();
      restart = 1'b0;
      chk("rs_fail",  int'(fail), 0);
      chk("rs_retry", int'(retry_cnt), 0);
      chk("rs_pll",   int'(pll_rst), 1);

      // Restart coincident with a WAIT_LOCK timeout
      while (cyc < r + 36) step();
      chk("rt_waiting_pll", int'(pll_rst), 0);
      clear_marks();
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("rt_retry", int'(retry_cnt), 0);
      chk("rt_pll",   int'(pll_rst), 1);
      while (cyc < r + 45) step();
      chk("rt_pll_fall", pll_fall, r + 41);

      // Reset mid-STABLE
      pll_lock = 1'b1;
      do_reset(2);
      while (cyc < 8) step();
      reset = 1'b1;
      step();
      chk_reset_vals("mid");
      reset = 1'b0;
      cyc = 0;
      clear_marks();
      while (cyc < 30) step();
      chk("mid_pll_fall", pll_fall, 4);
      chk("mid_sys_fall", sys_fall, 12);
      chk("mid_rtc_fall", rtc_fall, 16);

      // Randomized lock, restart and reset activity
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            pll_lock = ~pll_lock;
            if (pll_lock) hold = $urandom_range(1, 80);
            else if ($urandom_range(0, 9) == 0) hold = $urandom_range(100, 200);
            else hold = $urandom_range(1, 50);
         end
         hold--;
         restart = ($urandom_range(0, 199) == 0);
         reset   = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 1'b0;
      restart = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
